// File: rtl/i2c_arb_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Package : i2c_arb_pkg
// Brief   : State/grant encodings and derived cycle counts for i2c_bus_arbiter.
// Rev     : 1.0
// -----------------------------------------------------------------------------
package i2c_arb_pkg;

   localparam logic [3:0] c_IDLE    = 4'b0001;
   localparam logic [3:0] c_GRANT0  = 4'b0010;
   localparam logic [3:0] c_GRANT1  = 4'b0100;
   localparam logic [3:0] c_RELEASE = 4'b1000;

   localparam logic [1:0] c_GNT_NONE = 2'b00;
   localparam logic [1:0] c_GNT_M0   = 2'b01;
   localparam logic [1:0] c_GNT_M1   = 2'b10;

   // Bus-free gap after a release, roughly one half bus period (tBUF).
   function automatic int buf_cycles(input int clk_freq, input int i2c_freq);
      return clk_freq / i2c_freq / 2;
   endfunction

   function automatic int timeout_cycles(input int clk_freq, input int timeout_us);
      return clk_freq / 1_000_000 * timeout_us;
   endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_line_monitor.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module : i2c_line_monitor
// Brief  : Synchronises one master's SCL/SDA and flags START, STOP, SCL edges.
// Rev    : 1.0
// -----------------------------------------------------------------------------
module i2c_line_monitor (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic scl_i,
   input  logic sda_i,
   output logic start_o,
   output logic stop_o,
   output logic scl_edge_o
);

   logic r_scl_meta, r_scl_sync, r_scl_prev;
   logic r_sda_meta, r_sda_sync, r_sda_prev;

   // Idle I2C lines are high, so reset to 1 to avoid a false edge on release.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_scl_meta <= 1'b1;
         r_scl_sync <= 1'b1;
         r_scl_prev <= 1'b1;
         r_sda_meta <= 1'b1;
         r_sda_sync <= 1'b1;
         r_sda_prev <= 1'b1;
      end else begin
         r_scl_meta <= scl_i;
         r_scl_sync <= r_scl_meta;
         r_scl_prev <= r_scl_sync;
         r_sda_meta <= sda_i;
         r_sda_sync <= r_sda_meta;
         r_sda_prev <= r_sda_sync;
      end
   end

   // SCL must be high on both samples so SDA moves during SCL low never count.
   assign start_o    = r_scl_sync & r_scl_prev &  r_sda_prev & ~r_sda_sync;
   assign stop_o     = r_scl_sync & r_scl_prev & ~r_sda_prev &  r_sda_sync;
   assign scl_edge_o = r_scl_sync ^ r_scl_prev;

endmodule
`default_nettype wire

// File: rtl/i2c_bus_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module : i2c_bus_arbiter
// Brief  : Grants one slave bus to the first of two masters to START, stalls the other.
// Rev    : 1.0
// -----------------------------------------------------------------------------
module i2c_bus_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int CLK_FREQ   = 200_000_000,
   parameter int I2C_FREQ   = 100_000,
   parameter int TIMEOUT_US = 25_000
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       m0_scl_i,
   input  logic       m0_sda_i,
   input  logic       m1_scl_i,
   input  logic       m1_sda_i,
   output logic       m0_scl_hold_o,
   output logic       m1_scl_hold_o,
   output logic [1:0] grant_o,
   output logic       busy_o,
   output logic       timeout_o
);

   localparam int c_BUF_CYCLES     = buf_cycles(CLK_FREQ, I2C_FREQ);
   localparam int c_TIMEOUT_CYCLES = timeout_cycles(CLK_FREQ, TIMEOUT_US);
   localparam int c_BUF_W = (c_BUF_CYCLES > 1) ? $clog2(c_BUF_CYCLES) : 1;
   localparam int c_TO_W  = (c_TIMEOUT_CYCLES > 1) ? $clog2(c_TIMEOUT_CYCLES) : 1;
   localparam logic [c_BUF_W-1:0] c_BUF_LAST = c_BUF_W'(c_BUF_CYCLES - 1);
   localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(c_TIMEOUT_CYCLES - 1);

   logic               w_start0, w_stop0, w_scl_edge0;
   logic               w_start1, w_stop1, w_scl_edge1;
   logic [3:0]         r_state, w_next_state;
   logic [1:0]         r_last_grant;
   logic               r_timeout, w_timeout;
   logic [c_TO_W-1:0]  r_to_cnt;
   logic [c_BUF_W-1:0] r_buf_cnt;

   i2c_line_monitor u_mon0 (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .scl_i      (m0_scl_i),
      .sda_i      (m0_sda_i),
      .start_o    (w_start0),
      .stop_o     (w_stop0),
      .scl_edge_o (w_scl_edge0)
   );

   i2c_line_monitor u_mon1 (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .scl_i      (m1_scl_i),
      .sda_i      (m1_sda_i),
      .start_o    (w_start1),
      .stop_o     (w_stop1),
      .scl_edge_o (w_scl_edge1)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state      <= c_IDLE;
         r_last_grant <= c_GNT_M1;
         r_timeout    <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_timeout <= w_timeout;
         if (r_state == c_GRANT0) begin
            r_last_grant <= c_GNT_M0;
         end else if (r_state == c_GRANT1) begin
            r_last_grant <= c_GNT_M1;
         end
      end
   end

   // Stuck-bus and bus-free counters; both saturate rather than wrap.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_to_cnt  <= '0;
         r_buf_cnt <= '0;
      end else begin
         if ((r_state == c_GRANT0 && !w_scl_edge0) || (r_state == c_GRANT1 && !w_scl_edge1)) begin
            if (r_to_cnt != c_TO_LAST) begin
               r_to_cnt <= r_to_cnt + 1'b1;
            end
         end else begin
            r_to_cnt <= '0;
         end
         if (r_state == c_RELEASE) begin
            if (r_buf_cnt != c_BUF_LAST) begin
               r_buf_cnt <= r_buf_cnt + 1'b1;
            end
         end else begin
            r_buf_cnt <= '0;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_timeout    = 1'b0;
      case (r_state)
         c_IDLE: begin
            if (w_start0 && w_start1) begin
               w_next_state = (r_last_grant == c_GNT_M1) ? c_GRANT0 : c_GRANT1;
            end else if (w_start0) begin
               w_next_state = c_GRANT0;
            end else if (w_start1) begin
               w_next_state = c_GRANT1;
            end
         end
         c_GRANT0: begin
            if (w_stop0) begin
               w_next_state = c_RELEASE;
            end else if (r_to_cnt == c_TO_LAST && !w_scl_edge0) begin
               w_next_state = c_RELEASE;
               w_timeout    = 1'b1;
            end
         end
         c_GRANT1: begin
            if (w_stop1) begin
               w_next_state = c_RELEASE;
            end else if (r_to_cnt == c_TO_LAST && !w_scl_edge1) begin
               w_next_state = c_RELEASE;
               w_timeout    = 1'b1;
            end
         end
         c_RELEASE: begin
            if (r_buf_cnt == c_BUF_LAST) begin
               w_next_state = c_IDLE;
            end
         end
         default: w_next_state = c_IDLE;
      endcase
   end

   // The loser keeps being stalled through the bus-free gap.
   always_comb begin
      grant_o       = c_GNT_NONE;
      m0_scl_hold_o = 1'b0;
      m1_scl_hold_o = 1'b0;
      busy_o        = 1'b0;
      case (r_state)
         c_GRANT0: begin
            grant_o       = c_GNT_M0;
            m1_scl_hold_o = 1'b1;
            busy_o        = 1'b1;
         end
         c_GRANT1: begin
            grant_o       = c_GNT_M1;
            m0_scl_hold_o = 1'b1;
            busy_o        = 1'b1;
         end
         c_RELEASE: begin
            busy_o        = 1'b1;
            m0_scl_hold_o = (r_last_grant == c_GNT_M1);
            m1_scl_hold_o = (r_last_grant == c_GNT_M0);
         end
         default: ;
      endcase
   end

   assign timeout_o = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module : tb_i2c_bus_arbiter
// Brief  : Directed self-checking bench for i2c_bus_arbiter.
// Rev    : 1.0
// -----------------------------------------------------------------------------
module tb_i2c_bus_arbiter;

   localparam int c_BUF = 1000;   // 200 MHz / 100 kHz / 2
   localparam int c_TO  = 2000;   // 200 cycles/us * 10 us
   localparam int c_H   = 8;      // bench half-bit time in clk

   logic       clk_i = 1'b0;
   logic       rst_n_i = 1'b0;
   logic [1:0] scl_pin = 2'b11;
   logic [1:0] sda_pin = 2'b11;
   logic       m0_scl_hold_o, m1_scl_hold_o, busy_o, timeout_o;
   logic [1:0] grant_o;

   int n_cmp = 0;
   int n_mis = 0;
   int n_viol = 0;
   int n_inv = 0;
   logic       watch_en = 1'b0;
   logic [1:0] watch_grant = 2'b00;
   logic       watch_h0 = 1'b0;
   logic       watch_h1 = 1'b0;

   typedef struct packed {
      logic       scl0, scl1, fall0, fall1;
      logic [1:0] grant;
      logic       h0, h1, busy;
   } vec_t;
   vec_t vecs [0:6];

   i2c_bus_arbiter #(
      .CLK_FREQ   (200_000_000),
      .I2C_FREQ   (100_000),
      .TIMEOUT_US (10)
   ) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .m0_scl_i      (scl_pin[0]),
      .m0_sda_i      (sda_pin[0]),
      .m1_scl_i      (scl_pin[1]),
      .m1_sda_i      (sda_pin[1]),
      .m0_scl_hold_o (m0_scl_hold_o),
      .m1_scl_hold_o (m1_scl_hold_o),
      .grant_o       (grant_o),
      .busy_o        (busy_o),
      .timeout_o     (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         #1;
         if (watch_en && (grant_o !== watch_grant || m0_scl_hold_o !== watch_h0 ||
                          m1_scl_hold_o !== watch_h1))
            n_viol++;
         if (grant_o == 2'b11 || (m0_scl_hold_o && m1_scl_hold_o))
            n_inv++;
      end
   endtask

   task automatic do_reset();
      watch_en = 1'b0;
      rst_n_i  = 1'b0;
      scl_pin  = 2'b11;
      sda_pin  = 2'b11;
      tick(2);
      rst_n_i = 1'b1;
      tick(2);
   endtask

   task automatic watch(input logic [1:0] g, input logic h0, input logic h1);
      watch_grant = g;
      watch_h0    = h0;
      watch_h1    = h1;
      n_viol      = 0;
      watch_en    = 1'b1;
   endtask

   // Bit helpers assume SCL low on entry and leave it low.
   task automatic send_bit(input int m, input logic b);
      sda_pin[m] = b;
      tick(c_H);
      scl_pin[m] = 1'b1;
      tick(c_H);
      scl_pin[m] = 1'b0;
      tick(c_H);
   endtask

   task automatic send_byte(input int m, input logic [7:0] d);
      for (int i = 7; i >= 0; i--) send_bit(m, d[i]);
      send_bit(m, 1'b1);
   endtask

   task automatic start_scl_low(input int m);
      sda_pin[m] = 1'b0;
      tick(c_H);
      scl_pin[m] = 1'b0;
      tick(c_H);
   endtask

   // Leaves SDA just risen with SCL high; caller times the detection.
   task automatic stop_cond(input int m);
      sda_pin[m] = 1'b0;
      tick(c_H);
      scl_pin[m] = 1'b1;
      tick(c_H);
      sda_pin[m] = 1'b1;
   endtask

   task automatic wait_idle(input string nm);
      int k = 0;
      while (busy_o !== 1'b0 && k < 3000) begin
         tick(1);
         k++;
      end
      check(nm, busy_o, 1'b0);
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1};
      vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1};

      do_reset();
      check("rst grant", grant_o, 2'b00);
      check("rst h0", m0_scl_hold_o, 1'b0);
      check("rst h1", m1_scl_hold_o, 1'b0);
      check("rst busy", busy_o, 1'b0);
      check("rst timeout", timeout_o, 1'b0);

      // IDLE decisions from reset: plain STARTs, tie, and SDA moves under SCL low.
      for (int i = 0; i < 7; i++) begin
         do_reset();
         scl_pin = {vecs[i].scl1, vecs[i].scl0};
         tick(4);
         sda_pin = {~vecs[i].fall1, ~vecs[i].fall0};
         tick(3);
         check($sformatf("vec%0d grant", i), grant_o, vecs[i].grant);
         check($sformatf("vec%0d h0", i), m0_scl_hold_o, vecs[i].h0);
         check($sformatf("vec%0d h1", i), m1_scl_hold_o, vecs[i].h1);
         check($sformatf("vec%0d busy", i), busy_o, vecs[i].busy);
      end

      // m0 START, two bytes, STOP, then bus-free gap.
      do_reset();
      sda_pin[0] = 1'b0;
      tick(2);
      check("A latency2 grant", grant_o, 2'b00);
      tick(1);
      check("A latency3 grant", grant_o, 2'b01);
      check("A h1", m1_scl_hold_o, 1'b1);
      watch(2'b01, 1'b0, 1'b1);
      scl_pin[0] = 1'b0;
      tick(c_H);
      send_byte(0, 8'hA5);
      send_byte(0, 8'h3C);
      stop_cond(0);
      tick(2);
      watch_en = 1'b0;
      check("A xfer watch", n_viol, 0);
      tick(1);
      check("A release grant", grant_o, 2'b00);
      check("A release busy", busy_o, 1'b1);
      check("A release h1", m1_scl_hold_o, 1'b1);
      tick(c_BUF - 1);
      check("A gap busy", busy_o, 1'b1);
      check("A gap h1", m1_scl_hold_o, 1'b1);
      tick(1);
      check("A idle busy", busy_o, 1'b0);
      check("A idle h1", m1_scl_hold_o, 1'b0);

      // Simultaneous STARTs alternate between masters.
      do_reset();
      sda_pin = 2'b00;
      tick(3);
      check("B tie1 grant", grant_o, 2'b01);
      check("B tie1 h1", m1_scl_hold_o, 1'b1);
      sda_pin[1] = 1'b1;
      tick(c_H);
      check("B loser stop ignored", grant_o, 2'b01);
      scl_pin[0] = 1'b0;
      tick(c_H);
      scl_pin[0] = 1'b1;
      tick(c_H);
      sda_pin[0] = 1'b1;
      tick(3);
      check("B stop grant", grant_o, 2'b00);
      wait_idle("B idle");
      sda_pin = 2'b00;
      tick(3);
      check("B tie2 grant", grant_o, 2'b10);
      check("B tie2 h0", m0_scl_hold_o, 1'b1);

      // m1 owns; m0 runs a full transaction that must be ignored.
      do_reset();
      sda_pin[1] = 1'b0;
      tick(3);
      check("C grant", grant_o, 2'b10);
      watch(2'b10, 1'b1, 1'b0);
      start_scl_low(0);
      send_byte(0, 8'h96);
      stop_cond(0);
      tick(3);
      watch_en = 1'b0;
      check("C held watch", n_viol, 0);
      check("C owner kept", grant_o, 2'b10);

      // Repeated START by the owner keeps the grant.
      do_reset();
      sda_pin[0] = 1'b0;
      tick(3);
      check("D grant", grant_o, 2'b01);
      watch(2'b01, 1'b0, 1'b1);
      scl_pin[0] = 1'b0;
      tick(c_H);
      send_byte(0, 8'h50);
      sda_pin[0] = 1'b1;
      tick(c_H);
      scl_pin[0] = 1'b1;
      tick(c_H);
      sda_pin[0] = 1'b0;
      tick(c_H);
      scl_pin[0] = 1'b0;
      tick(c_H);
      send_byte(0, 8'hFF);
      stop_cond(0);
      tick(2);
      watch_en = 1'b0;
      check("D rstart watch", n_viol, 0);
      tick(1);
      check("D stop grant", grant_o, 2'b00);

      // Stuck bus: SCL held high after START.
      do_reset();
      sda_pin[0] = 1'b0;
      tick(3);
      check("E grant", grant_o, 2'b01);
      tick(c_TO - 1);
      check("E early timeout", timeout_o, 1'b0);
      check("E early grant", grant_o, 2'b01);
      tick(1);
      check("E timeout pulse", timeout_o, 1'b1);
      check("E timeout grant", grant_o, 2'b00);
      check("E timeout busy", busy_o, 1'b1);
      tick(1);
      check("E pulse width", timeout_o, 1'b0);
      wait_idle("E idle");
      check("E idle h1", m1_scl_hold_o, 1'b0);

      // Asynchronous reset in the middle of a GRANT1 transaction.
      do_reset();
      sda_pin[1] = 1'b0;
      tick(3);
      check("F grant", grant_o, 2'b10);
      check("F h0", m0_scl_hold_o, 1'b1);
      #2 rst_n_i = 1'b0;
      #1;
      check("F async grant", grant_o, 2'b00);
      check("F async h0", m0_scl_hold_o, 1'b0);
      check("F async h1", m1_scl_hold_o, 1'b0);
      check("F async busy", busy_o, 1'b0);
      sda_pin = 2'b11;
      tick(2);
      rst_n_i = 1'b1;
      tick(2);
      sda_pin[0] = 1'b0;
      tick(3);
      check("F regrant", grant_o, 2'b01);
      check("F regrant h1", m1_scl_hold_o, 1'b1);

      check("invariants", n_inv, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
